// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared constants, FSM encodings and digit-count helper for the BCD converter
package bin2bcd_seq_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  // minimum digit count holding 2**width-1 (floor(width*log10(2))+1)
  function automatic int bcd_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction
endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bin2bcd_seq_add3: double-dabble correction cell, adds 3 to a BCD digit that is >= 5
//   d_i  in  4  digit before correction
//   d_o  out 4  corrected digit
module bin2bcd_seq_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);
  always_comb d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one binary bit per clock under start/done
//   clk    in   1         clock
//   rst_n  in   1         async active-low reset
//   start  in   1         conversion request, sampled while idle
//   bin    in   WIDTH     binary operand captured on accepted start
//   busy   out  1         conversion in progress
//   done   out  1         one-cycle pulse, bcd/ovf just updated
//   bcd    out  4*DIGITS  packed BCD result, digit 0 in [3:0]
//   ovf    out  1         result exceeded DIGITS digits
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [DIGITS*BCD_DIGIT_W-1:0] bcd,
  output logic                          ovf
);
  localparam int BW = DIGITS * BCD_DIGIT_W;
  localparam int WW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  logic [0:0]    state_q, state_d;
  logic [WW-1:0] work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [BW-1:0] corr;
  logic [WW-1:0] shifted;
  logic          out_bit;
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_add3
      bin2bcd_seq_add3 u_add3 (
        .d_i(work_q[WIDTH + i*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .d_o(corr[i*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate
  // the corrected top bit leaves the register on this shift; any 1 there is overflow
  assign out_bit = corr[BW-1];
  assign shifted = {corr[BW-2:0], work_q[WIDTH-1:0], 1'b0};
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d  = ST_SHIFT;
        work_d   = {{BW{1'b0}}, bin};
        cnt_d    = CW'(WIDTH);
        sticky_d = 1'b0;
      end
    end else begin
      work_d   = shifted;
      cnt_d    = cnt_q - 1'b1;
      sticky_d = sticky_q | out_bit;
      if (cnt_q == CW'(1)) begin
        bcd_d   = shifted[WW-1 -: BW];
        ovf_d   = sticky_q | out_bit;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench driving a 5-digit and a 4-digit converter with the same operands
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy5, done5, ovf5, busy4, done4, ovf4;
  logic [19:0] bcd5;
  logic [15:0] bcd4;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  typedef struct {
    logic [19:0] b5;
    logic        o5;
    logic [15:0] b4;
    logic        o4;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy5), .done(done5), .bcd(bcd5), .ovf(ovf5)
  );
  bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: decimal digits by repeated division, overflow if anything remains
  function automatic exp_t model(input int unsigned v, input int c);
    exp_t e;
    int unsigned r;
    r = v;
    e.b5 = '0;
    for (int d = 0; d < 5; d++) begin
      e.b5[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.o5 = (r != 0);
    r = v;
    e.b4 = '0;
    for (int d = 0; d < 4; d++) begin
      e.b4[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.o4 = (r != 0);
    e.cyc = c;
    return e;
  endfunction

  // waits (bounded) for idle, then presents start for one edge
  task automatic issue(input logic [15:0] v);
    int n;
    n = 0;
    while (busy5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy5) chk("idle_timeout", 32'(busy5), 32'd0);
    start = 1'b1;
    bin = v;
    sb.push_back(model(v, cyc + 17));
    @(posedge clk);
    #1;
    start = 1'b0;
    bin = 16'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done5) chk("done_timeout", 32'(done5), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // monitor: pops on done, checks value, latency, busy length and digit range
  int   busy_run = 0;
  logic [19:0] last5 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
      last5 = '0;
    end else begin
      if (done5 !== done4) chk("done_align", 32'(done4), 32'(done5));
      if (done5) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done5), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("bcd5", 32'(bcd5), 32'(e.b5));
          chk("ovf5", 32'(ovf5), 32'(e.o5));
          chk("bcd4", 32'(bcd4), 32'(e.b4));
          chk("ovf4", 32'(ovf4), 32'(e.o4));
          chk("latency", 32'(cyc), 32'(e.cyc));
          chk("busy_len", 32'(busy_run), 32'd16);
          for (int d = 0; d < 5; d++) chk("digit5_le9", 32'(bcd5[4*d +: 4] <= 4'd9), 32'd1);
          for (int d = 0; d < 4; d++) chk("digit4_le9", 32'(bcd4[4*d +: 4] <= 4'd9), 32'd1);
        end
        last5 = bcd5;
      end else if (bcd5 !== last5) begin
        chk("bcd_held", 32'(bcd5), 32'(last5));
        last5 = bcd5;
      end
      busy_run = busy5 ? busy_run + 1 : (done5 ? busy_run : 0);
      if (done5) busy_run = busy5 ? 1 : 0;
    end
  end

  initial begin
    #12;
    chk("rst_busy", 32'(busy5), 32'd0);
    chk("rst_done", 32'(done5), 32'd0);
    chk("rst_bcd", 32'(bcd5), 32'd0);
    chk("rst_ovf", 32'(ovf5), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(16'hFFFF);
    drain();
    issue(16'd0);
    issue(16'd1);
    issue(16'd9);
    issue(16'd10);
    drain();
    issue(16'd1234);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      start = ~start;
      bin = 16'd999;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    drain();
    issue(16'd4095);
    wait_done();
    issue(16'd9999);
    drain();
    issue(16'd65535);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy5), 32'd0);
    chk("abort_done", 32'(done5), 32'd0);
    chk("abort_bcd", 32'(bcd5), 32'd0);
    chk("abort_ovf", 32'(ovf5), 32'd0);
    chk("abort_bcd4", 32'(bcd4), 32'd0);
    chk("abort_ovf4", 32'(ovf4), 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("post_abort_bcd", 32'(bcd5), 32'd0);
    issue(16'd31415);
    drain();
    issue(16'd10000);
    issue(16'd9999);
    issue(16'd100);
    for (int k = 0; k < 200; k++) issue(16'($urandom));
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
